brick_hit_arbiter: RTL and testbench

//   Central controller for the brick wall. Collects the 2-bit hit codes from N brick instances and

---
 rtl/breakout_pkg.sv | 15 +
 rtl/brick_prio_enc.sv | 26 ++
 rtl/brick_hit_arbiter.sv | 171 +++++++++++++++++
 tb/tb_brick_hit_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared hit codes and arbiter state encoding for the brick wall.
// Included by brick_prio_enc and brick_hit_arbiter.
package breakout_pkg;

   localparam logic [1:0] HIT_NONE   = 2'b00;
   localparam logic [1:0] HIT_V      = 2'b01;
   localparam logic [1:0] HIT_H      = 2'b10;
   localparam logic [1:0] HIT_CORNER = 2'b11;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PLAY    = 2'd1;
   localparam logic [1:0] RESOLVE = 2'd2;
   localparam logic [1:0] CLEAR   = 2'd3;

endpackage

// File: rtl/brick_prio_enc.sv
// Lowest-index-first priority encoder over the pending brick vector.
// Returns the winning index and a valid flag.
module brick_prio_enc
   import breakout_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan from the top so the lowest set bit is the last write.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/brick_hit_arbiter.sv
// Brick wall controller: serialises brick hits once per frame, merges bounces.
// Optional COMBO_SCORE_EN scales points by a paddle-cleared combo counter.
module brick_hit_arbiter
   import breakout_pkg::*;
#(
   parameter int N_BRICKS  = 8,
   parameter int POINTS    = 1,
   parameter int SCORE_W   = 9,
   parameter int COMBO_MAX = 7,
   localparam int CNT_W    = $clog2(N_BRICKS + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_ani_stb,
   input  logic                  i_mode,
   input  logic                  i_start,
   input  logic                  i_paddle_hit,
   input  logic [2*N_BRICKS-1:0] i_hit,
   output logic [N_BRICKS-1:0]   o_brick_ack,
   output logic                  o_flip_x,
   output logic                  o_flip_y,
   output logic [SCORE_W-1:0]    o_score,
   output logic [CNT_W-1:0]      o_remaining,
   output logic                  o_level_clear
);

   localparam int IW = (N_BRICKS > 1) ? $clog2(N_BRICKS) : 1;

   logic [1:0]          state;
   logic [N_BRICKS-1:0] alive;
   logic [N_BRICKS-1:0] pending;
   logic [1:0]          code [N_BRICKS];
   logic                fx;
   logic                fy;

   logic [N_BRICKS-1:0] hit_nz;
   logic [N_BRICKS-1:0] gmask;
   logic [N_BRICKS-1:0] pend_nxt;
   logic [IW-1:0]       g;
   logic                g_valid;
   logic                take;
   logic                capture;
   logic                fx_nxt;
   logic                fy_nxt;
   logic [CNT_W-1:0]    rem_nxt;
   logic [SCORE_W:0]    add_pts;
   logic [SCORE_W:0]    sum;
   logic [SCORE_W-1:0]  score_nxt;
   logic                start_go;

   brick_prio_enc #(.N(N_BRICKS), .IW(IW)) u_enc (
      .req   (pending),
      .idx   (g),
      .valid (g_valid)
   );

   assign capture  = i_mode && (state == PLAY || state == RESOLVE);
   assign take     = i_mode && (state == RESOLVE) && g_valid;
   assign start_go = i_mode && (state == IDLE) && i_start;

`ifdef COMBO_SCORE_EN
   localparam int CW = (COMBO_MAX > 0) ? $clog2(COMBO_MAX + 1) : 1;
   logic [CW-1:0] combo;

   assign add_pts = (SCORE_W + 1)'(POINTS * (int'(combo) + 1));

   // Paddle contact wins over a same-cycle grant increment.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         combo <= '0;
      end else if (start_go || i_paddle_hit) begin
         combo <= '0;
      end else if (take && int'(combo) < COMBO_MAX) begin
         combo <= combo + 1'b1;
      end
   end
`else
   logic unused_paddle;
   assign unused_paddle = i_paddle_hit;
   assign add_pts = (SCORE_W + 1)'(POINTS);
`endif

   always_comb begin
      hit_nz = '0;
      for (int i = 0; i < N_BRICKS; i++) begin
         hit_nz[i] = |i_hit[2*i +: 2];
      end
      gmask     = g_valid ? (N_BRICKS'(1) << g) : '0;
      pend_nxt  = (pending | (hit_nz & alive)) & ~gmask;
      fx_nxt    = fx | (g_valid & code[g][1]);
      fy_nxt    = fy | (g_valid & code[g][0]);
      rem_nxt   = (o_remaining != '0) ? o_remaining - 1'b1 : '0;
      sum       = {1'b0, o_score} + add_pts;
      score_nxt = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
   end

   assign o_brick_ack   = take ? gmask : '0;
   assign o_level_clear = (state == CLEAR);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < N_BRICKS; i++) code[i] <= HIT_NONE;
      end else if (capture) begin
         for (int i = 0; i < N_BRICKS; i++) begin
            if (hit_nz[i] && alive[i]) code[i] <= i_hit[2*i +: 2];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         alive       <= '1;
         pending     <= '0;
         fx          <= 1'b0;
         fy          <= 1'b0;
         o_flip_x    <= 1'b0;
         o_flip_y    <= 1'b0;
         o_score     <= '0;
         o_remaining <= CNT_W'(N_BRICKS);
      end else begin
         o_flip_x <= 1'b0;
         o_flip_y <= 1'b0;
         if (!i_mode) begin
            state       <= IDLE;
            alive       <= '1;
            pending     <= '0;
            fx          <= 1'b0;
            fy          <= 1'b0;
            o_remaining <= CNT_W'(N_BRICKS);
         end else begin
            unique case (state)
               IDLE: begin
                  if (i_start) begin
                     state   <= PLAY;
                     o_score <= '0;
                  end
               end
               PLAY: begin
                  pending <= pending | (hit_nz & alive);
                  if (i_ani_stb && pending != '0) state <= RESOLVE;
               end
               RESOLVE: begin
                  if (g_valid) begin
                     alive       <= alive & ~gmask;
                     pending     <= pend_nxt;
                     o_remaining <= rem_nxt;
                     o_score     <= score_nxt;
                  end
                  // New hits keep the grant loop going until nothing is left.
                  if (!g_valid || pend_nxt == '0) begin
                     o_flip_x <= fx_nxt;
                     o_flip_y <= fy_nxt;
                     fx       <= 1'b0;
                     fy       <= 1'b0;
                     if (g_valid) state <= (rem_nxt == '0) ? CLEAR : PLAY;
                     else state <= (o_remaining == '0) ? CLEAR : PLAY;
                  end else begin
                     fx <= fx_nxt;
                     fy <= fy_nxt;
                  end
               end
               CLEAR: begin
                  state <= CLEAR;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_brick_hit_arbiter.sv
// Directed, table-driven bench for brick_hit_arbiter.
// Frame vectors plus hand sequences for clear, restart, combo and reset.
module tb_brick_hit_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stb;
   logic        mode;
   logic        start;
   logic        paddle;
   logic [15:0] hit;
   logic [7:0]  ack;
   logic        flip_x;
   logic        flip_y;
   logic [8:0]  score;
   logic [3:0]  remaining;
   logic        level_clear;

   int checks = 0;
   int errors = 0;

   brick_hit_arbiter dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_ani_stb     (stb),
      .i_mode        (mode),
      .i_start       (start),
      .i_paddle_hit  (paddle),
      .i_hit         (hit),
      .o_brick_ack   (ack),
      .o_flip_x      (flip_x),
      .o_flip_y      (flip_y),
      .o_score       (score),
      .o_remaining   (remaining),
      .o_level_clear (level_clear)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]     hit;
      logic [3:0][7:0] acks;
      logic [2:0]      n_acks;
      logic            fx;
      logic            fy;
      logic [8:0]      score;
      logic [8:0]      score_combo;
      logic [3:0]      rem;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] pick(input logic [8:0] plain,
                                       input logic [8:0] combo);
`ifdef COMBO_SCORE_EN
      return combo;
`else
      return plain;
`endif
   endfunction

   task automatic run_frame(input vec_t v);
      hit = v.hit;
      cyc();
      hit = '0;
      stb = 1'b1;
      cyc();
      stb = 1'b0;
      if (v.n_acks == 0) chk("no_ack", 32'(ack), 32'h0);
      for (int k = 0; k < int'(v.n_acks); k++) begin
         if (k > 0) cyc();
         chk("ack", 32'(ack), 32'(v.acks[k]));
      end
      cyc();
      chk("flip_x", 32'(flip_x), 32'(v.fx));
      chk("flip_y", 32'(flip_y), 32'(v.fy));
      chk("score", 32'(score), 32'(pick(v.score, v.score_combo)));
      chk("remaining", 32'(remaining), 32'(v.rem));
      chk("ack_idle", 32'(ack), 32'h0);
      cyc();
      chk("flip_pulse_end", 32'({flip_x, flip_y}), 32'h0);
   endtask

   initial begin
      vecs[0] = '{16'h0040, {8'h00, 8'h00, 8'h00, 8'h08}, 3'd1,
                  1'b0, 1'b1, 9'd1, 9'd1, 4'd7};
      vecs[1] = '{16'h0804, {8'h00, 8'h00, 8'h20, 8'h02}, 3'd2,
                  1'b1, 1'b1, 9'd3, 9'd6, 4'd5};
      vecs[2] = '{16'h0110, {8'h00, 8'h00, 8'h10, 8'h04}, 3'd2,
                  1'b0, 1'b1, 9'd5, 9'd15, 4'd3};
      vecs[3] = '{16'h0040, {8'h00, 8'h00, 8'h00, 8'h00}, 3'd0,
                  1'b0, 1'b0, 9'd5, 9'd15, 4'd3};
      vecs[4] = '{16'h6003, {8'h00, 8'h80, 8'h40, 8'h01}, 3'd3,
                  1'b1, 1'b1, 9'd8, 9'd36, 4'd0};

      rst_n  = 1'b0;
      stb    = 1'b0;
      mode   = 1'b0;
      start  = 1'b0;
      paddle = 1'b0;
      hit    = '0;
      cyc();
      cyc();
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_flip", 32'({flip_x, flip_y}), 32'h0);
      chk("rst_score", 32'(score), 32'h0);
      chk("rst_remaining", 32'(remaining), 32'd8);
      chk("rst_clear", 32'(level_clear), 32'h0);
      rst_n = 1'b1;
      mode  = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;

      for (int i = 0; i < 5; i++) run_frame(vecs[i]);

      chk("level_clear", 32'(level_clear), 32'h1);
      hit = 16'h0001;
      cyc();
      hit = '0;
      stb = 1'b1;
      cyc();
      stb = 1'b0;
      chk("clear_ignores_hit", 32'(ack), 32'h0);
      mode = 1'b0;
      cyc();
      chk("idle_remaining", 32'(remaining), 32'd8);
      chk("idle_score_held", 32'(score), 32'(pick(9'd8, 9'd36)));
      chk("idle_clear_low", 32'(level_clear), 32'h0);

      mode  = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("restart_score", 32'(score), 32'h0);
      run_frame('{16'h0015, {8'h00, 8'h04, 8'h02, 8'h01}, 3'd3,
                  1'b0, 1'b1, 9'd3, 9'd6, 4'd5});
      paddle = 1'b1;
      cyc();
      paddle = 1'b0;
      run_frame('{16'h0040, {8'h00, 8'h00, 8'h00, 8'h08}, 3'd1,
                  1'b0, 1'b1, 9'd4, 9'd7, 4'd4});

      hit = 16'h0500;
      cyc();
      hit = '0;
      stb = 1'b1;
      cyc();
      stb = 1'b0;
      chk("pre_reset_ack", 32'(ack), 32'h10);
      rst_n = 1'b0;
      #1;
      chk("async_ack_drop", 32'(ack), 32'h0);
      chk("async_remaining", 32'(remaining), 32'd8);
      chk("async_score", 32'(score), 32'h0);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("post_reset_ack", 32'(ack), 32'h0);
      cyc();
      chk("post_reset_flip", 32'({flip_x, flip_y}), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
